// File: rtl/calc_disp_pkg.sv
// calc_disp_pkg
//   Shared definitions for the calculator display driver:
//   - disp_state_e : conversion FSM states
//   - glyph_e      : 5-bit glyph codes held in the display buffer
//   - RANGE_MAX / RANGE_MIN : displayable signed range
//   - glyph_to_seg : glyph -> {g,f,e,d,c,b,a} active-high segment pattern
//   - digit_glyph  : BCD nibble -> glyph code
package calc_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ABS    = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_COMMIT = 2'd3
    } disp_state_e;

    typedef enum logic [4:0] {
        GL_0     = 5'd0,
        GL_1     = 5'd1,
        GL_2     = 5'd2,
        GL_3     = 5'd3,
        GL_4     = 5'd4,
        GL_5     = 5'd5,
        GL_6     = 5'd6,
        GL_7     = 5'd7,
        GL_8     = 5'd8,
        GL_9     = 5'd9,
        GL_MINUS = 5'd10,
        GL_E     = 5'd11,
        GL_R     = 5'd12,
        GL_BLANK = 5'd13
    } glyph_e;

    localparam int RANGE_MAX = 9999;
    localparam int RANGE_MIN = -999;

    function automatic logic [6:0] glyph_to_seg(input glyph_e g);
        logic [6:0] s;
        case (g)
            GL_0:     s = 7'h3F;
            GL_1:     s = 7'h06;
            GL_2:     s = 7'h5B;
            GL_3:     s = 7'h4F;
            GL_4:     s = 7'h66;
            GL_5:     s = 7'h6D;
            GL_6:     s = 7'h7D;
            GL_7:     s = 7'h07;
            GL_8:     s = 7'h7F;
            GL_9:     s = 7'h6F;
            GL_MINUS: s = 7'h40;
            GL_E:     s = 7'h79;
            GL_R:     s = 7'h50;
            GL_BLANK: s = 7'h00;
            default:  s = 7'h00;
        endcase
        return s;
    endfunction

    // Nibbles above 9 only arise for out-of-range magnitudes, whose digits
    // are never shown; map them to BLANK so the result is still a legal code.
    function automatic glyph_e digit_glyph(input logic [3:0] d);
        glyph_e g;
        if (d <= 4'd9) begin
            g = glyph_e'({1'b0, d});
        end else begin
            g = GL_BLANK;
        end
        return g;
    endfunction

endpackage

// File: rtl/calc_bin2bcd.sv
// calc_bin2bcd
//   Sequential double-dabble converter: 16 iterations, one per cycle.
//   Ports:
//     clk     : clock, rising edge
//     rst     : synchronous active-high reset
//     start_i : load bin_i and begin converting (ignored checks: the parent
//               only raises it while the core is idle)
//     bin_i   : 16-bit unsigned magnitude
//     done_o  : high during the final iteration; bcd_o is final from the
//               following cycle onward
//     bcd_o   : 4 x 4-bit BCD, thousands in [15:12]. Magnitudes above 9999
//               overflow the four nibbles and produce meaningless digits.
module calc_bin2bcd
    import calc_disp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [15:0] bin_i,
    output logic        done_o,
    output logic [15:0] bcd_o
);

    logic [15:0] bin_q;
    logic [15:0] bcd_q;
    logic [3:0]  cnt_q;
    logic        active_q;
    logic [15:0] bcd_adj;

    // Add-3 correction on every nibble that would reach 10 or more after
    // the upcoming shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start_i) begin
            bin_q    <= bin_i;
            bcd_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            bcd_q <= {bcd_adj[14:0], bin_q[15]};
            bin_q <= {bin_q[14:0], 1'b0};
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
                active_q <= 1'b0;
            end
        end
    end

    assign done_o = active_q && (cnt_q == 4'd15);
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/calc_display_driver.sv
// calc_display_driver
//   Display end of the calculator: accepts a signed 16-bit result over a
//   valid/ready handshake, converts it to BCD and drives a 4-digit
//   time-multiplexed seven-segment display.
//
//   Handshake: a transfer happens on any rising edge where in_valid and
//   in_ready are both high; in_value is sampled only on that edge. in_valid
//   raised while in_ready is low is ignored, not queued.
//
//   Parameter:
//     SCAN_DIV : cycles each digit stays enabled (>= 2)
//   Ports:
//     clk      : clock, rising edge
//     rst      : synchronous active-high reset, wins over a handshake
//     in_value : two's-complement result
//     in_valid : in_value presented
//     in_ready : converter idle
//     seg      : {g,f,e,d,c,b,a}, active-high, registered
//     dig_en   : one-hot digit enable, bit 3 = leftmost, registered
//     busy     : conversion in progress (inverse of in_ready)
//
//   Build option: define CALC_DISP_LZB_EN for leading-zero blanking.
module calc_display_driver
    import calc_disp_pkg::*;
#(
    parameter int SCAN_DIV = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_value,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [6:0]  seg,
    output logic [3:0]  dig_en,
    output logic        busy
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

`ifdef CALC_DISP_LZB_EN
    localparam glyph_e RST_HI = GL_BLANK;
`else
    localparam glyph_e RST_HI = GL_0;
`endif

    // ---------------- conversion FSM ----------------
    disp_state_e state_q, state_d;
    logic [15:0] value_q;
    logic        neg_q;
    logic        oor_q;
    logic        start;
    logic        commit;
    logic        conv_done;
    logic [15:0] bcd;
    logic [15:0] abs_mag;
    logic signed [31:0] value_s;
    logic        out_of_range;

    glyph_e buf_q [4];
    glyph_e commit_buf [4];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_ABS;
                end
            end
            ST_ABS: begin
                start   = 1'b1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (conv_done) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                commit  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready = (state_q == ST_IDLE);
    assign busy     = ~in_ready;

    // Magnitude of -32768 is 0x8000, still representable unsigned; it is
    // out of range anyway.
    assign value_s      = {{16{value_q[15]}}, value_q};
    assign abs_mag      = value_q[15] ? (~value_q + 16'd1) : value_q;
    assign out_of_range = (value_s > RANGE_MAX) || (value_s < RANGE_MIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            neg_q   <= 1'b0;
            oor_q   <= 1'b0;
        end else begin
            if (in_ready && in_valid) begin
                value_q <= in_value;
            end
            if (state_q == ST_ABS) begin
                neg_q <= value_q[15];
                oor_q <= out_of_range;
            end
        end
    end

    calc_bin2bcd u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .bin_i   (abs_mag),
        .done_o  (conv_done),
        .bcd_o   (bcd)
    );

    // ---------------- glyph assembly ----------------
`ifdef CALC_DISP_LZB_EN
    logic lead;
`endif

    always_comb begin
        commit_buf[0] = digit_glyph(bcd[3:0]);
        commit_buf[1] = digit_glyph(bcd[7:4]);
        commit_buf[2] = digit_glyph(bcd[11:8]);
        commit_buf[3] = digit_glyph(bcd[15:12]);
`ifdef CALC_DISP_LZB_EN
        lead = 1'b1;
`endif
        if (oor_q) begin
            commit_buf[3] = GL_E;
            commit_buf[2] = GL_R;
            commit_buf[1] = GL_R;
            commit_buf[0] = GL_BLANK;
        end else begin
            // In-range negatives are at most 999, so the thousands nibble
            // is free for the sign.
            if (neg_q) begin
                commit_buf[3] = GL_MINUS;
            end
`ifdef CALC_DISP_LZB_EN
            // Walk from the left; the sign is skipped and units never blank.
            for (int i = 3; i >= 1; i--) begin
                if (commit_buf[i] != GL_MINUS) begin
                    if (lead && (commit_buf[i] == GL_0)) begin
                        commit_buf[i] = GL_BLANK;
                    end else begin
                        lead = 1'b0;
                    end
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q[3] <= RST_HI;
            buf_q[2] <= RST_HI;
            buf_q[1] <= RST_HI;
            buf_q[0] <= GL_0;
        end else if (commit) begin
            for (int i = 0; i < 4; i++) begin
                buf_q[i] <= commit_buf[i];
            end
        end
    end

    // ---------------- digit scan ----------------
    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]       dig_idx_q, dig_idx_d;
    logic [3:0]       dig_en_q;
    logic [6:0]       seg_q;
    logic             scan_wrap;

    always_comb begin
        scan_wrap  = (scan_cnt_q == CNT_W'(SCAN_DIV - 1));
        scan_cnt_d = scan_wrap ? '0 : (scan_cnt_q + CNT_W'(1));
        dig_idx_d  = scan_wrap ? (dig_idx_q + 2'd1) : dig_idx_q;
    end

    // seg is looked up with the digit index that dig_en takes on the same
    // edge, so the two registers always describe the same digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q <= '0;
            dig_idx_q  <= 2'd0;
            dig_en_q   <= 4'b0001;
            seg_q      <= 7'h3F;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            dig_idx_q  <= dig_idx_d;
            dig_en_q   <= 4'b0001 << dig_idx_d;
            seg_q      <= glyph_to_seg(buf_q[dig_idx_d]);
        end
    end

    assign seg    = seg_q;
    assign dig_en = dig_en_q;

endmodule

// File: tb/tb_calc_display_driver.sv
// tb_calc_display_driver
//   Self-checking bench for calc_display_driver with SCAN_DIV = 4.
//   Expected display contents come from an arithmetic model of the glyph
//   rules; expected scan position comes from a cycle count since reset.
//   Honours CALC_DISP_LZB_EN the same way as the design.
module tb_calc_display_driver;

    localparam int SCAN_DIV = 4;
    localparam int G_MINUS = 10;
    localparam int G_E     = 11;
    localparam int G_R     = 12;
    localparam int G_BLANK = 13;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_value;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int sc = 0;
    int exp_glyph [4];
    int exp_q [$];

    calc_display_driver #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_value (in_value),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .seg      (seg),
        .dig_en   (dig_en),
        .busy     (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Cycles since the last reset edge; the enabled digit is derived from it.
    always @(posedge clk) begin
        if (rst) sc <= 0;
        else     sc <= sc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    function automatic int glyph_seg(input int g);
        case (g)
            0: return 'h3F;
            1: return 'h06;
            2: return 'h5B;
            3: return 'h4F;
            4: return 'h66;
            5: return 'h6D;
            6: return 'h7D;
            7: return 'h07;
            8: return 'h7F;
            9: return 'h6F;
            G_MINUS: return 'h40;
            G_E: return 'h79;
            G_R: return 'h50;
            default: return 'h00;
        endcase
    endfunction

    // ---------------- reference model ----------------
    task automatic model_reset();
`ifdef CALC_DISP_LZB_EN
        exp_glyph[3] = G_BLANK;
        exp_glyph[2] = G_BLANK;
        exp_glyph[1] = G_BLANK;
`else
        exp_glyph[3] = 0;
        exp_glyph[2] = 0;
        exp_glyph[1] = 0;
`endif
        exp_glyph[0] = 0;
    endtask

    task automatic model_set(input int v);
        int m;
        if (v > 9999 || v < -999) begin
            exp_glyph[3] = G_E;
            exp_glyph[2] = G_R;
            exp_glyph[1] = G_R;
            exp_glyph[0] = G_BLANK;
        end else begin
            m = (v < 0) ? -v : v;
            exp_glyph[0] = m % 10;
            exp_glyph[1] = (m / 10) % 10;
            exp_glyph[2] = (m / 100) % 10;
            exp_glyph[3] = (v < 0) ? G_MINUS : (m / 1000) % 10;
`ifdef CALC_DISP_LZB_EN
            for (int i = 3; i >= 1; i--) begin
                if (exp_glyph[i] == G_MINUS) continue;
                if (exp_glyph[i] != 0) break;
                exp_glyph[i] = G_BLANK;
            end
`endif
        end
    endtask

    // Samples n successive cycles and compares the scanned digit and its
    // segments against the model.
    task automatic check_display(input string tag, input int n);
        int d;
        repeat (n) begin
            @(negedge clk);
            d = (sc / SCAN_DIV) % 4;
            check({tag, "_dig_en"}, int'(dig_en), 1 << d);
            check({tag, "_seg"}, int'(seg), glyph_seg(exp_glyph[d]));
        end
    endtask

    task automatic wait_ready(input int bound);
        int n = 0;
        while (!in_ready && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", 0, 1);
    endtask

    // ---------------- drivers ----------------
    // Sends one value; optionally pulses in_valid with junk while busy.
    task automatic send(input logic [15:0] v, input bit pulse);
        int k;
        wait_ready(60);
        in_value = v;
        in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(int'($signed(v)));
        @(negedge clk);
        in_valid = 1'b0;
        in_value = 16'($urandom);
        k = 1;
        while (!in_ready && k < 40) begin
            if (pulse && k >= 4 && k <= 8) begin
                in_valid = 1'b1;
                in_value = 16'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        in_valid = 1'b0;
        check("ready_latency", k, 19);
        check("busy_after", int'(busy), 0);
        model_set(exp_q.pop_front());
        check_display("value", 4 * SCAN_DIV + 1);
    endtask

    initial begin
        logic [15:0] rv;
        int k;
        int cat;

        // ---------------- reset ----------------
        rst = 1'b1;
        in_valid = 1'b0;
        in_value = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_seg", int'(seg), 'h3F);
        check("rst_dig_en", int'(dig_en), 1);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_busy", int'(busy), 0);
        model_reset();
        check_display("rst_scan", 17);

        // ---------------- directed values ----------------
        send(16'd1234, 1'b1);
        send(16'(-42), 1'b0);
        send(16'd10000, 1'b1);
        send(16'(-1000), 1'b0);
        send(16'h8000, 1'b0);
        send(16'd9999, 1'b0);
        send(16'(-999), 1'b1);
        send(16'd0, 1'b0);
        send(16'(-5), 1'b0);
        send(16'd70, 1'b0);

        // ---------------- back-to-back 7 then 8 ----------------
        wait_ready(60);
        in_value = 16'd7;
        in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(7);
        @(negedge clk);
        in_value = 16'd8;
        k = 1;
        while (!in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("b2b_accept", k, 19);
        @(posedge clk);
        exp_q.push_back(8);
        @(negedge clk);
        in_valid = 1'b0;
        k = 1;
        while (!in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("b2b_second", k, 19);
        check("b2b_queue", exp_q.size(), 2);
        while (exp_q.size() > 0) model_set(exp_q.pop_front());
        check_display("b2b", 4 * SCAN_DIV + 1);

        // ---------------- reset mid-conversion ----------------
        wait_ready(60);
        in_value = 16'd5555;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        k = 1;
        while (k < 10) begin
            @(negedge clk);
            k++;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_ready", int'(in_ready), 1);
        check("rst_mid_busy", int'(busy), 0);
        model_reset();
        check_display("rst_mid", 30);
        check("rst_mid_ready_after", int'(in_ready), 1);

        // ---------------- random values ----------------
        repeat (12) begin
            cat = $urandom_range(0, 3);
            case (cat)
                0: rv = 16'($urandom_range(0, 9999));
                1: rv = 16'(-$urandom_range(1, 999));
                2: rv = 16'($urandom_range(0, 65535));
                default: rv = 16'($urandom_range(0, 99));
            endcase
            send(rv, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
